// File: rtl/cpu_trace_buffer_if.sv
// Writeback tap and trace read-out bundle for cpu_trace_buffer.
// The master drives writes and rd_ready; the slave returns the head entry and status.
interface cpu_trace_buffer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [PC_W-1:0]   wb_pc;
  logic              rd_ready;
  logic              rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [PC_W-1:0]   rd_pc;
  logic [CYC_W-1:0]  rd_cycle;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              run_done;
  logic [CYC_W-1:0]  cycle_count;

  modport master (
    output wb_en, wb_addr, wb_data, wb_pc, rd_ready,
    input  rd_valid, rd_addr, rd_data, rd_pc, rd_cycle,
    input  count, overflow, run_done, cycle_count
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, wb_pc, rd_ready,
    output rd_valid, rd_addr, rd_data, rd_pc, rd_cycle,
    output count, overflow, run_done, cycle_count
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular writeback trace with cycle timestamps and a run budget.
// Define CPU_TRACE_ZERO_FILTER_EN to drop writes to register 0.
module cpu_trace_buffer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int PC_W       = 32,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 16,
  parameter int MAX_CYCLES = 20
) (
  input logic             clk,
  input logic             reset,
  cpu_trace_buffer_if.slave trc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [PC_W-1:0]   pc;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic [CYC_W-1:0] cyc;
  logic             ovf;
  logic             done;
  logic             keep;
  logic             push;
  logic             pop;
  logic             full;
  logic             both;
  logic             drop;
  logic             fill;
  logic             take;

  assign done = cyc == CYC_W'(MAX_CYCLES);
  assign full = cnt == CNT_W'(DEPTH);

`ifdef CPU_TRACE_ZERO_FILTER_EN
  assign keep = trc.wb_addr != '0;
`else
  assign keep = 1'b1;
`endif

  assign push = trc.wb_en && !done && keep;
  assign pop  = (cnt != '0) && trc.rd_ready;

  // one-hot view of the four pointer/count transitions
  assign both = push && pop;
  assign drop = push && !pop && full;
  assign fill = push && !pop && !full;
  assign take = pop && !push;

  assign head             = mem[rptr];
  assign trc.rd_valid     = cnt != '0;
  assign trc.rd_addr      = head.addr;
  assign trc.rd_data      = head.data;
  assign trc.rd_pc        = head.pc;
  assign trc.rd_cycle     = head.cycle;
  assign trc.count        = cnt;
  assign trc.overflow     = ovf;
  assign trc.run_done     = done;
  assign trc.cycle_count  = cyc;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc <= '0;
    end else if (!done) begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      unique case (1'b1)
        both: begin
          wptr <= wptr + PTR_W'(1);
          rptr <= rptr + PTR_W'(1);
        end
        drop: begin
          wptr <= wptr + PTR_W'(1);
          rptr <= rptr + PTR_W'(1);
          ovf  <= 1'b1;
        end
        fill: begin
          wptr <= wptr + PTR_W'(1);
          cnt  <= cnt + CNT_W'(1);
        end
        take: begin
          rptr <= rptr + PTR_W'(1);
          cnt  <= cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // storage is never cleared; count alone decides what is valid
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wptr] <= '{
        addr:  trc.wb_addr,
        data:  trc.wb_data,
        pc:    trc.wb_pc,
        cycle: cyc
      };
    end
  end
endmodule
